relu_stream_ctrl: RTL and testbench
===================================

Name: relu_stream_ctrl

Overview:
- Sequences a WIDTH-lane ReLU datapath (relu_forward) over a tensor held in a vector-wide source buffer, and writes results to a destination buffer.
- On start, reads ceil(num_elems/WIDTH) vectors, feeds each into the ReLU lanes, tracks the datapath latency with a valid pipeline, and issues masked writes. It pulses done after the last write retires.
- Sits between the layer scheduler and the ReLU unit plus its activation buffers.

Parameters:
- WIDTH, 8, lanes per vector; each lane is a 32-bit IEEE-754 single.
- ADDR_W, 16, vector address width for the source and destination buffers.
- CNT_W, 20, element-count width.
- RELU_LAT, 1, clocks from relu_in_data to a valid relu_out_data (1..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; low freezes all state; forwarded to the ReLU unit.
- start  in  1  one-cycle launch; sampled only in IDLE.
- num_elems  in  CNT_W  element count, latched on start.
- src_base  in  ADDR_W  first source vector address, latched on start.
- dst_base  in  ADDR_W  first destination vector address, latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  source read strobe.
- rd_addr  out  ADDR_W  source vector address.
- rd_data  in  WIDTH*32  source data, valid 1 clk-enabled cycle after rd_en.
- relu_in_data  out  WIDTH*32  lanes to ReLU; lane k occupies bits [32k+31:32k].
- relu_out_data  in  WIDTH*32  lanes from ReLU.
- wr_en  out  1  destination write strobe.
- wr_addr  out  ADDR_W  destination vector address.
- wr_data  out  WIDTH*32  equals relu_out_data when wr_en is high.
- wr_mask  out  WIDTH  per-lane write enable.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE.
  - busy, done, rd_en, wr_en, wr_mask, rd_addr, wr_addr and all counters are 0.
  - relu_in_data=0 and the valid pipeline is cleared.
  - Reset mid-run abandons the run; no further rd_en or wr_en is issued.
- All registers update only on clk rising edges with clk_en=1. With clk_en=0 every output holds its value, including strobes (the buffers are also clk_en-gated).
- Vector count: NV = ceil(num_elems/WIDTH), computed at start.
  - Last-vector mask: low (num_elems mod WIDTH) lanes set, or all lanes set if the remainder is 0.
  - All other vectors use an all-ones mask.
- FSM states:
  - IDLE: start=1 with num_elems>0 latches the inputs, sets busy and goes to ISSUE. start=1 with num_elems=0 goes to FIN (done with no reads or writes).
  - ISSUE: one rd_en per enabled cycle, with rd_addr=src_base+v for v=0..NV-1. After the read for v=NV-1, go to DRAIN.
  - DRAIN: wait until the valid pipeline is empty, then go to FIN.
  - FIN: done=1 for one enabled cycle, busy=0, then go to IDLE.
- Datapath timing:
  - relu_in_data is a register loaded from rd_data one cycle after rd_en.
  - Lanes with a clear mask bit are loaded with 0.
  - The valid/mask/index pipeline has depth 1+RELU_LAT.
  - wr_en for vector v asserts exactly 2+RELU_LAT enabled cycles after its rd_en, with wr_addr=dst_base+v and wr_mask as computed above.
- Throughput: one vector per enabled cycle. Total run is NV+2+RELU_LAT cycles from start to done, plus 1.
- Address arithmetic wraps modulo 2^ADDR_W; no error is flagged.
- start while busy is ignored; the latched parameters do not change mid-run.
- done and start in the same cycle: start is ignored, since FIN is not IDLE.

Test Plan:
- num_elems=16, WIDTH=8, src_base=0x10, dst_base=0x40, lanes mixing 0x3F800000 (1.0) and 0xBF800000 (-1.0):
  - rd_addr 0x10, 0x11 on consecutive cycles;
  - wr_en at +3 cycles (RELU_LAT=1) with wr_addr 0x40, 0x41 and wr_mask=0xFF;
  - wr_data lanes are 0x3F800000 or 0x00000000;
  - done 1 cycle after the last write.
- num_elems=11 -> 2 vectors; second wr_mask=0x07; relu_in_data lanes 3..7 are 0 for the second vector.
- num_elems=0 -> no rd_en or wr_en; done pulses 1 cycle after start; busy stays 0.
- clk_en toggled 1,0,0,1 during ISSUE with num_elems=32 -> outputs frozen during the low cycles; write addresses 0x40..0x43 are each written exactly once, in order.
- reset_n pulled low mid-DRAIN -> wr_en, busy and done go to 0 immediately; a subsequent start with num_elems=8 completes normally with 1 write.
- start re-asserted while busy with num_elems=99 -> ignored; the original count is honoured and exactly one done pulse occurs.

Source files
------------

// File: rtl/relu_stream_ctrl.sv
// rtl/relu_stream_ctrl.sv - sequences vector reads through a WIDTH-lane ReLU unit into a destination buffer
// One vector per enabled cycle; a valid/mask/address pipeline tracks each vector until its write.
module relu_stream_ctrl #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 20,
  parameter int RELU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_elems,
  input  logic [ADDR_W-1:0]     src_base,
  input  logic [ADDR_W-1:0]     dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [WIDTH*32-1:0]   rd_data,
  output logic [WIDTH*32-1:0]   relu_in_data,
  input  logic [WIDTH*32-1:0]   relu_out_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [WIDTH*32-1:0]   wr_data,
  output logic [WIDTH-1:0]      wr_mask
);

  // Stage 0 lines up with rd_data; stage RELU_LAT lines up with relu_out_data one cycle before the write.
  localparam int DEPTH = RELU_LAT + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t              state;
  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [CNT_W:0]      nv_q;
  logic [CNT_W:0]      v_q;
  logic [WIDTH-1:0]    last_mask_q;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [DEPTH-1:0]    pv;
  logic [WIDTH-1:0]    pm [DEPTH];
  logic [ADDR_W-1:0]   pa [DEPTH];

  logic [CNT_W:0]      nv_calc;
  logic [CNT_W-1:0]    rem_calc;
  logic [WIDTH-1:0]    last_mask_calc;
  logic                is_last;
  logic [WIDTH-1:0]    cur_mask;
  logic [WIDTH*32-1:0] in_masked;

  // Reset asserts asynchronously but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    nv_calc  = ({1'b0, num_elems} + (CNT_W+1)'(WIDTH - 1)) / (CNT_W+1)'(WIDTH);
    rem_calc = num_elems % CNT_W'(WIDTH);
    last_mask_calc = '0;
    for (int k = 0; k < WIDTH; k++) begin
      last_mask_calc[k] = (rem_calc == '0) || (CNT_W'(k) < rem_calc);
    end
  end

  always_comb begin
    is_last  = ((v_q + (CNT_W+1)'(1)) == nv_q);
    cur_mask = is_last ? last_mask_q : '1;
  end

  // Lanes beyond the tensor end are forced to zero before they reach the ReLU unit.
  always_comb begin
    in_masked = '0;
    for (int k = 0; k < WIDTH; k++) begin
      in_masked[32*k +: 32] = pm[0][k] ? rd_data[32*k +: 32] : 32'h0;
    end
  end

  assign wr_data = relu_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_mask      <= '0;
      relu_in_data <= '0;
      nv_q         <= '0;
      v_q          <= '0;
      last_mask_q  <= '0;
      dst_ptr      <= '0;
      pv           <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pm[i] <= '0;
        pa[i] <= '0;
      end
    end else if (clk_en) begin
      pv[0] <= rd_en;
      pm[0] <= cur_mask;
      pa[0] <= dst_ptr;
      for (int i = 1; i < DEPTH; i++) begin
        pv[i] <= pv[i-1];
        pm[i] <= pm[i-1];
        pa[i] <= pa[i-1];
      end

      if (pv[0]) begin
        relu_in_data <= in_masked;
      end

      wr_en   <= pv[DEPTH-1];
      wr_mask <= pv[DEPTH-1] ? pm[DEPTH-1] : '0;
      if (pv[DEPTH-1]) begin
        wr_addr <= pa[DEPTH-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (num_elems != '0) begin
              nv_q        <= nv_calc;
              last_mask_q <= last_mask_calc;
              v_q         <= '0;
              rd_addr     <= src_base;
              dst_ptr     <= dst_base;
              rd_en       <= 1'b1;
              busy        <= 1'b1;
              state       <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        ISSUE: begin
          if (is_last) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            v_q     <= v_q + (CNT_W+1)'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
            dst_ptr <= dst_ptr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Empty pipeline here means the final write is on the bus this cycle.
          if (pv == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb/tb_relu_stream_ctrl.sv - directed self-checking bench for relu_stream_ctrl
// Behavioural source buffer and one-cycle ReLU surround the DUT; a negedge monitor logs strobes.
module tb_relu_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clk_en;
  logic         start;
  logic [19:0]  num_elems;
  logic [15:0]  src_base;
  logic [15:0]  dst_base;
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [15:0]  rd_addr;
  logic [255:0] rd_data;
  logic [255:0] relu_in_data;
  logic [255:0] relu_out_data;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [255:0] wr_data;
  logic [7:0]   wr_mask;

  int checks = 0;
  int fails  = 0;

  logic [255:0] src_mem [256];
  int           ecyc = 0;
  int           start_cyc = 0;
  int           rd_n = 0, wr_n = 0, done_n = 0, busy_n = 0;
  logic [15:0]  rd_addr_log [64];
  int           rd_cyc_log  [64];
  logic [15:0]  wr_addr_log [64];
  logic [7:0]   wr_mask_log [64];
  logic [255:0] wr_data_log [64];
  int           wr_cyc_log  [64];
  int           done_cyc_log [64];
  logic [255:0] relu_hist [64];

  relu_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .num_elems(num_elems), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .relu_in_data(relu_in_data), .relu_out_data(relu_out_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clk_en) begin
      ecyc <= ecyc + 1;
      if (rd_en) rd_data <= src_mem[rd_addr[7:0]];
      for (int k = 0; k < 8; k++) begin
        relu_out_data[32*k +: 32] <= relu_in_data[32*k+31] ? 32'h0 : relu_in_data[32*k +: 32];
      end
    end
  end

  always @(negedge clk) begin
    relu_hist[ecyc % 64] = relu_in_data;
    if (clk_en) begin
      if (start) start_cyc = ecyc;
      if (busy) busy_n++;
      if (rd_en && rd_n < 64) begin
        rd_addr_log[rd_n] = rd_addr; rd_cyc_log[rd_n] = ecyc; rd_n++;
      end
      if (wr_en && wr_n < 64) begin
        wr_addr_log[wr_n] = wr_addr; wr_mask_log[wr_n] = wr_mask;
        wr_data_log[wr_n] = wr_data; wr_cyc_log[wr_n] = ecyc; wr_n++;
      end
      if (done && done_n < 64) begin
        done_cyc_log[done_n] = ecyc; done_n++;
      end
    end
  end

  function automatic logic [255:0] lanes(input logic [31:0] ev, input logic [31:0] od, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[32*k +: 32] = (k % 2 == 0) ? ev : od;
    return r;
  endfunction

  task automatic run_start(input logic [19:0] n, input logic [15:0] s, input logic [15:0] d);
    @(posedge clk); #1;
    num_elems = n; src_base = s; dst_base = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int k;
    k = 0;
    while (done_n == base && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (done_n == base) begin
      fails++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required a pulse", name, k);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_mask !== 8'h00) begin fails++; $display("FAIL reset_wr_mask: got %h want 00", wr_mask); end
    checks++; if (rd_addr !== 16'h0) begin fails++; $display("FAIL reset_rd_addr: got %h want 0000", rd_addr); end
    checks++; if (wr_addr !== 16'h0) begin fails++; $display("FAIL reset_wr_addr: got %h want 0000", wr_addr); end
    checks++; if (relu_in_data !== 256'h0) begin fails++; $display("FAIL reset_relu_in: got %h want 0", relu_in_data); end
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle: busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_basic;
    int rb, wb, db;
    logic [255:0] exp_w [2];
    rb = rd_n; wb = wr_n; db = done_n;
    exp_w[0] = lanes(32'h3F800000, 32'h00000000, 8);
    exp_w[1] = lanes(32'h00000000, 32'h3F800000, 8);
    run_start(20'd16, 16'h0010, 16'h0040);
    wait_done(db, "basic");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rd_n - rb != 2) begin fails++; $display("FAIL basic_rd_count: got %0d want 2", rd_n - rb); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rd_addr_log[rb+i] !== 16'h0010 + 16'(i)) begin
        fails++; $display("FAIL basic_rd_addr%0d: got %h want %h", i, rd_addr_log[rb+i], 16'h0010 + 16'(i));
      end
      checks++; if (rd_cyc_log[rb+i] != start_cyc + 1 + i) begin
        fails++; $display("FAIL basic_rd_cycle%0d: got %0d want %0d", i, rd_cyc_log[rb+i], start_cyc + 1 + i);
      end
    end
    checks++; if (wr_n - wb != 2) begin fails++; $display("FAIL basic_wr_count: got %0d want 2", wr_n - wb); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (wr_addr_log[wb+i] !== 16'h0040 + 16'(i)) begin
        fails++; $display("FAIL basic_wr_addr%0d: got %h want %h", i, wr_addr_log[wb+i], 16'h0040 + 16'(i));
      end
      checks++; if (wr_mask_log[wb+i] !== 8'hFF) begin
        fails++; $display("FAIL basic_wr_mask%0d: got %h want ff", i, wr_mask_log[wb+i]);
      end
      checks++; if (wr_cyc_log[wb+i] != start_cyc + 4 + i) begin
        fails++; $display("FAIL basic_wr_cycle%0d: got %0d want %0d", i, wr_cyc_log[wb+i], start_cyc + 4 + i);
      end
      checks++; if (wr_data_log[wb+i] !== exp_w[i]) begin
        fails++; $display("FAIL basic_wr_data%0d: got %h want %h", i, wr_data_log[wb+i], exp_w[i]);
      end
    end
    checks++; if (done_n - db != 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_n - db); end
    checks++; if (done_cyc_log[db] != start_cyc + 6) begin
      fails++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc_log[db], start_cyc + 6);
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_partial;
    int rb, wb, db;
    logic [255:0] exp_part;
    logic [255:0] exp_full;
    rb = rd_n; wb = wr_n; db = done_n;
    exp_full = lanes(32'h40000000, 32'h40000000, 8);
    exp_part = lanes(32'h40000000, 32'h40000000, 3);
    run_start(20'd11, 16'h0020, 16'h0050);
    wait_done(db, "partial");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_n - wb != 2) begin fails++; $display("FAIL partial_wr_count: got %0d want 2", wr_n - wb); end
    checks++; if (wr_mask_log[wb] !== 8'hFF) begin fails++; $display("FAIL partial_mask0: got %h want ff", wr_mask_log[wb]); end
    checks++; if (wr_mask_log[wb+1] !== 8'h07) begin fails++; $display("FAIL partial_mask1: got %h want 07", wr_mask_log[wb+1]); end
    checks++; if (wr_data_log[wb] !== exp_full) begin fails++; $display("FAIL partial_data0: got %h want %h", wr_data_log[wb], exp_full); end
    checks++; if (wr_data_log[wb+1] !== exp_part) begin fails++; $display("FAIL partial_data1: got %h want %h", wr_data_log[wb+1], exp_part); end
    checks++; if (relu_hist[(rd_cyc_log[rb+1] + 2) % 64] !== exp_part) begin
      fails++; $display("FAIL partial_relu_in1: got %h want %h", relu_hist[(rd_cyc_log[rb+1] + 2) % 64], exp_part);
    end
    checks++; if (wr_addr_log[wb+1] !== 16'h0051) begin fails++; $display("FAIL partial_addr1: got %h want 0051", wr_addr_log[wb+1]); end
  endtask

  task automatic test_zero;
    int rb, wb, db, bb;
    rb = rd_n; wb = wr_n; db = done_n; bb = busy_n;
    run_start(20'd0, 16'h0010, 16'h0040);
    wait_done(db, "zero");
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rd_n != rb) begin fails++; $display("FAIL zero_reads: got %0d want 0", rd_n - rb); end
    checks++; if (wr_n != wb) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_n - wb); end
    checks++; if (busy_n != bb) begin fails++; $display("FAIL zero_busy_cycles: got %0d want 0", busy_n - bb); end
    checks++; if (done_cyc_log[db] != start_cyc + 1) begin
      fails++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc_log[db], start_cyc + 1);
    end
  endtask

  task automatic test_clk_en;
    int rb, wb, db;
    logic        s_rd_en, s_busy, s_wr_en;
    logic [15:0] s_rd_addr;
    rb = rd_n; wb = wr_n; db = done_n;
    run_start(20'd32, 16'h0030, 16'h0040);
    @(posedge clk); #1; clk_en = 1'b0;
    @(negedge clk);
    s_rd_en = rd_en; s_busy = busy; s_wr_en = wr_en; s_rd_addr = rd_addr;
    checks++; if (s_rd_addr !== 16'h0031) begin fails++; $display("FAIL clken_frozen_addr: got %h want 0031", s_rd_addr); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      clk_en = (c == 1);
      @(negedge clk);
      checks++; if (rd_en !== s_rd_en || rd_addr !== s_rd_addr) begin
        fails++; $display("FAIL clken_hold_rd%0d: got %b/%h want %b/%h", c, rd_en, rd_addr, s_rd_en, s_rd_addr);
      end
      checks++; if (busy !== s_busy || wr_en !== s_wr_en) begin
        fails++; $display("FAIL clken_hold_ctl%0d: got %b/%b want %b/%b", c, busy, wr_en, s_busy, s_wr_en);
      end
    end
    wait_done(db, "clken");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rd_n - rb != 4) begin fails++; $display("FAIL clken_rd_count: got %0d want 4", rd_n - rb); end
    checks++; if (wr_n - wb != 4) begin fails++; $display("FAIL clken_wr_count: got %0d want 4", wr_n - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr_log[wb+i] !== 16'h0040 + 16'(i) || wr_mask_log[wb+i] !== 8'hFF) begin
        fails++; $display("FAIL clken_wr%0d: got %h/%h want %h/ff", i, wr_addr_log[wb+i], wr_mask_log[wb+i], 16'h0040 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_drain;
    int wb, db, k;
    run_start(20'd16, 16'h0010, 16'h0040);
    k = 0;
    while (wr_en !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (wr_en !== 1'b1) begin fails++; $display("FAIL drain_reach: wr_en got %b want 1", wr_en); end
    reset_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      fails++; $display("FAIL drain_reset_outputs: wr_en=%b busy=%b done=%b rd_en=%b want 0000", wr_en, busy, done, rd_en);
    end
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
    wb = wr_n; db = done_n;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (wr_n != wb || done_n != db) begin
      fails++; $display("FAIL drain_abandoned: writes=%0d dones=%0d want 0 0", wr_n - wb, done_n - db);
    end
    run_start(20'd8, 16'h0010, 16'h0060);
    wait_done(db, "after_reset");
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_n - wb != 1) begin fails++; $display("FAIL after_reset_wr_count: got %0d want 1", wr_n - wb); end
    checks++; if (wr_addr_log[wb] !== 16'h0060 || wr_mask_log[wb] !== 8'hFF) begin
      fails++; $display("FAIL after_reset_wr: got %h/%h want 0060/ff", wr_addr_log[wb], wr_mask_log[wb]);
    end
    checks++; if (done_n - db != 1) begin fails++; $display("FAIL after_reset_done: got %0d want 1", done_n - db); end
  endtask

  task automatic test_start_busy;
    int rb, wb, db;
    rb = rd_n; wb = wr_n; db = done_n;
    run_start(20'd24, 16'h0010, 16'h0070);
    num_elems = 20'd99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(db, "start_busy");
    repeat (12) @(posedge clk);
    #1;
    checks++; if (done_n - db != 1) begin fails++; $display("FAIL busy_done_count: got %0d want 1", done_n - db); end
    checks++; if (rd_n - rb != 3) begin fails++; $display("FAIL busy_rd_count: got %0d want 3", rd_n - rb); end
    checks++; if (wr_n - wb != 3) begin fails++; $display("FAIL busy_wr_count: got %0d want 3", wr_n - wb); end
    checks++; if (wr_addr_log[wb+2] !== 16'h0072 || wr_mask_log[wb+2] !== 8'hFF) begin
      fails++; $display("FAIL busy_last_wr: got %h/%h want 0072/ff", wr_addr_log[wb+2], wr_mask_log[wb+2]);
    end
  endtask

  initial begin
    clk_en = 1'b1; start = 1'b0; num_elems = '0; src_base = '0; dst_base = '0;
    for (int a = 0; a < 256; a++) src_mem[a] = '0;
    src_mem[8'h10] = lanes(32'h3F800000, 32'hBF800000, 8);
    src_mem[8'h11] = lanes(32'hBF800000, 32'h3F800000, 8);
    src_mem[8'h12] = lanes(32'h3F800000, 32'h3F800000, 8);
    src_mem[8'h20] = lanes(32'h40000000, 32'h40000000, 8);
    src_mem[8'h21] = lanes(32'h40000000, 32'h40000000, 8);
    test_reset;
    test_basic;
    test_partial;
    test_zero;
    test_clk_en;
    test_reset_drain;
    test_start_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
